// File: rtl/keypad_pkg.sv
// Shared keypad definitions: FSM states, key-to-matrix decode and bounce LFSR taps.
package keypad_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BOUNCE_IN,
        ST_HOLD,
        ST_BOUNCE_OUT,
        ST_GAP
    } kp_state_e;

    // Right-shift Fibonacci form of taps 16,14,13,11: feedback from bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;

    function automatic logic [1:0] key_col_idx(input logic [3:0] key);
        return key[3:2];
    endfunction

    function automatic logic [1:0] key_row_idx(input logic [3:0] key);
        return key[1:0];
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] state);
        return {^(state & LFSR_TAP_MASK), state[15:1]};
    endfunction

endpackage

// File: rtl/keypad_matrix_emulator_if.sv
// Command handshake between a key-sequence source and the keypad emulator.
interface keypad_matrix_emulator_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_key;
    logic [15:0] cmd_hold;

    modport master (output cmd_valid, output cmd_key, output cmd_hold, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_key, input cmd_hold, output cmd_ready);

endinterface

// File: rtl/bounce_lfsr.sv
// 16-bit bounce-noise LFSR; advances only while enabled, synchronous reset to seed.
module bounce_lfsr
    import keypad_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic bit_out
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en) lfsr_d = lfsr_next(lfsr_q);
    end

    always_ff @(posedge clk) begin
        if (reset) lfsr_q <= SEED;
        else       lfsr_q <= lfsr_d;
    end

    assign bit_out = lfsr_q[0];

endmodule

// File: rtl/keypad_matrix_emulator.sv
// 4x4 membrane keypad model: scripted key presses with contact bounce, answering column strobes on active-low rows.
//   state      | meaning
//   IDLE       | ready for a command, contact open
//   BOUNCE_IN  | contact follows LFSR noise while the key goes down
//   HOLD       | contact stably closed for max(hold,1) cycles
//   BOUNCE_OUT | contact follows LFSR noise while the key comes up
//   GAP        | contact open; done pulses on the way back to IDLE
module keypad_matrix_emulator
    import keypad_pkg::*;
#(
    parameter int unsigned BOUNCE_CYCLES = 64,
    parameter int unsigned GAP_CYCLES    = 256,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic                            clk,
    input  logic                            reset,
    keypad_matrix_emulator_if.slave         cmd,
    input  logic [3:0]                      col,
    output logic [3:0]                      row,
    output logic                            busy,
    output logic                            done
);

    localparam logic        HAS_BOUNCE  = (BOUNCE_CYCLES != 0);
    localparam logic [15:0] BOUNCE_LOAD = HAS_BOUNCE ? 16'(BOUNCE_CYCLES - 1) : 16'd0;
    localparam logic [15:0] GAP_LOAD    = (GAP_CYCLES != 0) ? 16'(GAP_CYCLES - 1) : 16'd0;

    kp_state_e   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  key_q, key_d;
    logic [15:0] hold_load_q, hold_load_d;
    logic        contact_q, contact_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        ready_q, ready_d;
    logic        lfsr_en;
    logic        lfsr_bit;
    logic [15:0] hold_load_in;
    logic        cnt_zero;

    bounce_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .en      (lfsr_en),
        .bit_out (lfsr_bit)
    );

    // A zero hold still closes the contact for one cycle.
    assign hold_load_in = (cmd.cmd_hold == 16'd0) ? 16'd0 : cmd.cmd_hold - 16'd1;
    assign cnt_zero     = (cnt_q == 16'd0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        key_d       = key_q;
        hold_load_d = hold_load_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd.cmd_valid) begin
                    key_d       = cmd.cmd_key;
                    hold_load_d = hold_load_in;
                    if (HAS_BOUNCE) begin
                        state_d = ST_BOUNCE_IN;
                        cnt_d   = BOUNCE_LOAD;
                    end else begin
                        state_d = ST_HOLD;
                        cnt_d   = hold_load_in;
                    end
                end
            end
            ST_BOUNCE_IN: begin
                if (cnt_zero) begin
                    state_d = ST_HOLD;
                    cnt_d   = hold_load_q;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_HOLD: begin
                if (cnt_zero) begin
                    if (HAS_BOUNCE) begin
                        state_d = ST_BOUNCE_OUT;
                        cnt_d   = BOUNCE_LOAD;
                    end else begin
                        state_d = ST_GAP;
                        cnt_d   = GAP_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_BOUNCE_OUT: begin
                if (cnt_zero) begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_GAP: begin
                if (cnt_zero) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with state_q.
    always_comb begin
        lfsr_en   = (state_d == ST_BOUNCE_IN) || (state_d == ST_BOUNCE_OUT);
        busy_d    = (state_d != ST_IDLE);
        ready_d   = (state_d == ST_IDLE);
        contact_d = 1'b0;
        case (state_d)
            ST_BOUNCE_IN, ST_BOUNCE_OUT: contact_d = lfsr_bit;
            ST_HOLD:                     contact_d = 1'b1;
            default:                     contact_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 16'd0;
            key_q       <= 4'd0;
            hold_load_q <= 16'd0;
            contact_q   <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_q       <= key_d;
            hold_load_q <= hold_load_d;
            contact_q   <= contact_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
        end
    end

    always_comb begin
        row = 4'b1111;
        if (contact_q && !col[key_col_idx(key_q)]) row[key_row_idx(key_q)] = 1'b0;
    end

    assign cmd.cmd_ready = ready_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Scoreboard bench for keypad_matrix_emulator: a no-bounce instance and a default-parameter instance.
module tb_keypad_matrix_emulator;

    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk = 1'b0;
    logic       reset_a, reset_b;
    logic [3:0] col_a, col_b, row_a, row_b;
    logic       busy_a, busy_b, done_a, done_b;

    always #10 clk = ~clk;

    keypad_matrix_emulator_if kif_a ();
    keypad_matrix_emulator_if kif_b ();

    keypad_matrix_emulator #(.BOUNCE_CYCLES(0), .GAP_CYCLES(4), .LFSR_SEED(SEED)) dut_a (
        .clk(clk), .reset(reset_a), .cmd(kif_a.slave),
        .col(col_a), .row(row_a), .busy(busy_a), .done(done_a)
    );

    keypad_matrix_emulator #(.BOUNCE_CYCLES(64), .GAP_CYCLES(256), .LFSR_SEED(SEED)) dut_b (
        .clk(clk), .reset(reset_b), .cmd(kif_b.slave),
        .col(col_b), .row(row_b), .busy(busy_b), .done(done_b)
    );

    int          n_pass  = 0;
    int          n_total = 0;
    int          q_a[$];
    int          q_b[$];
    int          e_a, e_b;
    int          acc_a, acc_b;
    logic [15:0] m_lfsr;
    logic [3:0]  cp[5];

    function automatic int ncyc();
        return int'($time / 20);
    endfunction

    function automatic logic [15:0] m_step(input logic [15:0] s);
        logic fb;
        fb = s[0] ^ s[2] ^ s[3] ^ s[5];
        return {fb, s[15:1]};
    endfunction

    task automatic check(input bit ok, input string name, input int act, input int exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Scoreboards: every done pulse must match the next expected done time.
    always @(negedge clk) begin
        if (done_a) begin
            if (q_a.size() == 0) check(1'b0, "a_stray_done", ncyc(), -1);
            else begin
                e_a = q_a.pop_front();
                check(ncyc() == e_a, "a_done_time", ncyc(), e_a);
            end
        end
        if (done_b) begin
            if (q_b.size() == 0) check(1'b0, "b_stray_done", ncyc(), -1);
            else begin
                e_b = q_b.pop_front();
                check(ncyc() == e_b, "b_done_time", ncyc(), e_b);
            end
        end
    end

    // Called at a negedge; returns at the negedge one cycle after the accept edge.
    task automatic send_a(input logic [3:0] k, input logic [15:0] h, input int lat, input bit keep);
        int w;
        w = 0;
        kif_a.cmd_valid = 1'b1;
        kif_a.cmd_key   = k;
        kif_a.cmd_hold  = h;
        while (!kif_a.cmd_ready && w < 3000) begin
            @(negedge clk);
            w++;
        end
        check(kif_a.cmd_ready === 1'b1, "a_accept_wait", w, 0);
        acc_a = ncyc();
        if (lat > 0) q_a.push_back(acc_a + lat);
        @(negedge clk);
        if (!keep) kif_a.cmd_valid = 1'b0;
    endtask

    task automatic send_b(input logic [3:0] k, input logic [15:0] h, input int lat);
        int w;
        w = 0;
        kif_b.cmd_valid = 1'b1;
        kif_b.cmd_key   = k;
        kif_b.cmd_hold  = h;
        while (!kif_b.cmd_ready && w < 3000) begin
            @(negedge clk);
            w++;
        end
        check(kif_b.cmd_ready === 1'b1, "b_accept_wait", w, 0);
        acc_b = ncyc();
        if (lat > 0) q_b.push_back(acc_b + lat);
        @(negedge clk);
        kif_b.cmd_valid = 1'b0;
    endtask

    task automatic drain(input int limit);
        int w;
        w = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && w < limit) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
    endtask

    // Full press on dut_b, checking row every cycle against the bench's own contact model.
    task automatic run_b(input logic [3:0] k, input logic [15:0] h);
        int hh, total, bad_bi, bad_h, bad_bo, bad_gap, rise_in, rise_out;
        logic c, prev, obs;
        logic [3:0] p, er;
        hh = (h == 16'd0) ? 1 : int'(h);
        total = 128 + hh + 256;
        bad_bi = 0; bad_h = 0; bad_bo = 0; bad_gap = 0; rise_in = 0; rise_out = 0;
        prev = 1'b0;
        send_b(k, h, total + 1);
        for (int j = 1; j <= total; j++) begin
            if (j <= 64 || (j > 64 + hh && j <= 128 + hh)) begin
                c = m_lfsr[0];
                m_lfsr = m_step(m_lfsr);
                p = 4'b0000;
            end else begin
                c = (j <= 64 + hh);
                p = cp[j % 5];
            end
            col_b = p;
            #1;
            er = 4'b1111;
            if (c && !p[k[3:2]]) er[k[1:0]] = 1'b0;
            obs = !row_b[k[1:0]];
            if (row_b !== er) begin
                if (j <= 64) bad_bi++;
                else if (j <= 64 + hh) bad_h++;
                else if (j <= 128 + hh) bad_bo++;
                else bad_gap++;
            end
            if (j <= 64 && obs && !prev) rise_in++;
            if (j > 64 + hh && j <= 128 + hh && obs && !prev) rise_out++;
            if (p == 4'b0000) prev = obs;
            @(negedge clk);
        end
        check(bad_bi == 0,  "b_bounce_in_rows",  bad_bi, 0);
        check(bad_h == 0,   "b_hold_rows",       bad_h, 0);
        check(bad_bo == 0,  "b_bounce_out_rows", bad_bo, 0);
        check(bad_gap == 0, "b_gap_rows",        bad_gap, 0);
        check(rise_in > 0,  "b_bounce_in_toggle",  rise_in, 1);
        check(rise_out > 0, "b_bounce_out_toggle", rise_out, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [3:0] exp_row;
        int t0;
        cp[0] = 4'b1110; cp[1] = 4'b1101; cp[2] = 4'b1011; cp[3] = 4'b0111; cp[4] = 4'b0000;
        m_lfsr = SEED;
        kif_a.cmd_valid = 1'b0; kif_a.cmd_key = 4'd0; kif_a.cmd_hold = 16'd0;
        kif_b.cmd_valid = 1'b0; kif_b.cmd_key = 4'd0; kif_b.cmd_hold = 16'd0;
        col_a = 4'b1111; col_b = 4'b1111;
        reset_a = 1'b1; reset_b = 1'b1;
        repeat (3) @(negedge clk);
        reset_a = 1'b0; reset_b = 1'b0;
        @(negedge clk);

        check(kif_a.cmd_ready === 1'b1, "a_reset_ready", kif_a.cmd_ready, 1);
        check(busy_a === 1'b0,          "a_reset_busy",  busy_a, 0);
        check(done_a === 1'b0,          "a_reset_done",  done_a, 0);
        check(kif_b.cmd_ready === 1'b1, "b_reset_ready", kif_b.cmd_ready, 1);
        check(busy_b === 1'b0,          "b_reset_busy",  busy_b, 0);
        for (int i = 0; i < 5; i++) begin
            col_a = cp[i]; col_b = cp[i];
            #1;
            check(row_a === 4'b1111, "a_idle_row", row_a, 15);
            check(row_b === 4'b1111, "b_idle_row", row_b, 15);
        end
        @(negedge clk);

        // key 6, hold 10, no bounce, gap 4: done 15 cycles after accept
        send_a(4'd6, 16'd10, 15, 1'b0);
        for (int i = 0; i < 10; i++) begin
            col_a = cp[i % 5];
            #1;
            exp_row = cp[i % 5][1] ? 4'b1111 : 4'b1011;
            check(row_a === exp_row, "a_hold_row_key6", row_a, exp_row);
            check(busy_a === 1'b1, "a_busy_hold", busy_a, 1);
            @(negedge clk);
        end
        col_a = 4'b0000;
        #1;
        check(row_a === 4'b1111, "a_gap_row_key6", row_a, 15);
        drain(100);

        // hold 0 still gives one contact cycle: done 1+4+1 = 6 after accept
        send_a(4'd5, 16'd0, 6, 1'b0);
        col_a = 4'b1101;
        #1;
        check(row_a === 4'b1101, "a_hold0_row", row_a, 13);
        @(negedge clk);
        col_a = 4'b0000;
        #1;
        check(row_a === 4'b1111, "a_hold0_gap_row", row_a, 15);
        drain(100);

        // back-to-back: key 0 hold 2 (done +7), key 9 hold 3 (done +8)
        send_a(4'd0, 16'd2, 7, 1'b1);
        t0 = acc_a;
        send_a(4'd9, 16'd3, 8, 1'b0);
        check(acc_a - t0 == 7, "a_b2b_accept", acc_a - t0, 7);
        col_a = 4'b1011;
        #1;
        check(row_a === 4'b1101, "a_key9_row", row_a, 13);
        drain(100);

        // defaults: key 15 hold 1000 from the reset seed
        run_b(4'd15, 16'd1000);
        drain(100);

        // reset mid-HOLD drops the command
        send_b(4'd3, 16'd200, 0);
        repeat (114) @(negedge clk);
        col_b = 4'b0000;
        #1;
        check(row_b === 4'b0111, "b_pre_reset_row", row_b, 7);
        reset_b = 1'b1;
        @(negedge clk);
        reset_b = 1'b0;
        m_lfsr = SEED;
        #1;
        check(row_b === 4'b1111, "b_post_reset_row", row_b, 15);
        check(busy_b === 1'b0, "b_post_reset_busy", busy_b, 0);
        check(kif_b.cmd_ready === 1'b1, "b_post_reset_ready", kif_b.cmd_ready, 1);
        repeat (300) @(negedge clk);

        // same press again must replay the seed bounce pattern
        run_b(4'd15, 16'd1000);
        drain(100);

        check(q_a.size() == 0, "a_queue_empty", q_a.size(), 0);
        check(q_b.size() == 0, "b_queue_empty", q_b.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
